// File: rtl/io_out_fifo_pkg.sv
// ---------------------------------------------------------------------------
// io_out_fifo_pkg
//   Shared definitions for the core output-side buffer.
//   - Default widths/depth for the core output port.
//   - Operation encoding used to update the occupancy counter.
//   - Entry packing helpers: an entry is {addr[AW-1:0], data[NUBITS-1:0]},
//     entry width EW = AW + NUBITS. The input-side buffer uses the same layout.
// ---------------------------------------------------------------------------
package io_out_fifo_pkg;

  localparam int DEF_NUBITS = 32;
  localparam int DEF_NUIOOU = 8;
  localparam int DEF_FDEPTH = 8;

  // Per-edge FIFO activity, bit0 = push, bit1 = pop.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Classify the accepted push/pop pair for this edge.
  function automatic fifo_op_e op_decode(input logic push, input logic pop);
    fifo_op_e op;
    case ({pop, push})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

  // Address field width of an output port address.
  function automatic int addr_width(input int nuiou);
    return (nuiou > 1) ? $clog2(nuiou) : 1;
  endfunction

  // Pointer index width for a FIFO of the given depth (depth >= 2).
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/io_fifo_mem.sv
// ---------------------------------------------------------------------------
// io_fifo_mem
//   DEPTH x EW storage for the output FIFO. One synchronous write port and
//   one asynchronous (combinational) read port. Storage is intentionally not
//   reset; validity is tracked by the pointers in the parent.
// Ports
//   clk    in  1       clock
//   we     in  1       write enable
//   waddr  in  PW      write index
//   wdata  in  EW      packed entry to write
//   raddr  in  PW      read index
//   rdata  out EW      entry at raddr (combinational)
// ---------------------------------------------------------------------------
module io_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int EW    = 35,
  parameter int PW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/io_out_fifo.sv
// ---------------------------------------------------------------------------
// io_out_fifo
//   Output-side buffer directly downstream of the fixed-point core's output
//   port. Every core write ({addr_out, data_out} qualified by out_en) is
//   captured and later drained to peripherals over a valid/ready handshake.
//   The core cannot be stalled: writes arriving while full (and not covered
//   by a same-edge pop) are dropped and reported through sticky ovf.
// Ports
//   clk        in   1        clock
//   rst        in   1        asynchronous active-high reset
//   out_en     in   1        core output strobe
//   addr_out   in   AW       core output port address
//   data_out   in   NUBITS   core output data
//   ext_valid  out  1        head entry present
//   ext_addr   out  AW       head entry address (0 when not valid)
//   ext_data   out  NUBITS   head entry data (0 when not valid)
//   ext_ready  in   1        consumer accepts head entry
//   full       out  1        count == FDEPTH
//   count      out  PW+1     occupied entries
//   ovf        out  1        sticky: a write was dropped
//   ovf_clr    in   1        synchronous clear of ovf (a same-edge drop wins)
// All outputs are driven straight from flops. The head entry is computed one
// edge ahead from the next read pointer, so it stays show-ahead without a
// combinational path from the storage array to the pins.
// ---------------------------------------------------------------------------
module io_out_fifo
  import io_out_fifo_pkg::*;
#(
  parameter int NUBITS = DEF_NUBITS,
  parameter int NUIOOU = DEF_NUIOOU,
  parameter int FDEPTH = DEF_FDEPTH,
  localparam int AW = addr_width(NUIOOU),
  localparam int PW = ptr_width(FDEPTH),
  localparam int EW = AW + NUBITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_en,
  input  logic [AW-1:0]     addr_out,
  input  logic [NUBITS-1:0] data_out,
  output logic              ext_valid,
  output logic [AW-1:0]     ext_addr,
  output logic [NUBITS-1:0] ext_data,
  input  logic              ext_ready,
  output logic              full,
  output logic [PW:0]       count,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  // State registers.
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              full_q, full_d;
  logic              ext_valid_q, ext_valid_d;
  logic              ovf_q, ovf_d;
  logic [AW-1:0]     ext_addr_q, ext_addr_d;
  logic [NUBITS-1:0] ext_data_q, ext_data_d;

  // Combinational control.
  logic              ptr_full;
  logic              push;
  logic              pop;
  logic              drop;
  fifo_op_e          op;
  logic [EW-1:0]     wr_entry;
  logic [EW-1:0]     rd_entry;
  logic [EW-1:0]     head_entry;

  assign wr_entry = {addr_out, data_out};

  io_fifo_mem #(
    .DEPTH (FDEPTH),
    .EW    (EW),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[PW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr_d[PW-1:0]),
    .rdata (rd_entry)
  );

  // Handshake decode, pointer/count/flag next state and next head entry.
  always_comb begin
    ptr_full    = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    // ext_valid_q always mirrors ~empty of the current pointers.
    pop         = ext_valid_q & ext_ready;
    push        = out_en & (~ptr_full | pop);
    drop        = out_en & ptr_full & ~pop;
    op          = op_decode(push, pop);

    wr_ptr_d    = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d    = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    count_d     = count_q;
    case (op)
      OP_PUSH: count_d = count_q + PTR_ONE;
      OP_POP:  count_d = count_q - PTR_ONE;
      OP_BOTH: count_d = count_q;
      OP_IDLE: count_d = count_q;
      default: count_d = count_q;
    endcase

    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    full_d      = (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]) && (wr_ptr_d[PW] != rd_ptr_d[PW]);
    ext_valid_d = (wr_ptr_d != rd_ptr_d);

    // The storage write lands on this edge, so when the next head is the
    // slot being written right now the array still holds stale contents:
    // take the incoming entry instead.
    if (!ext_valid_d) begin
      head_entry = {EW{1'b0}};
    end else if (push && (rd_ptr_d == wr_ptr_q)) begin
      head_entry = wr_entry;
    end else begin
      head_entry = rd_entry;
    end

    ext_addr_d  = head_entry[EW-1:NUBITS];
    ext_data_d  = head_entry[NUBITS-1:0];
  end

  // State update; reset discards every buffered entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= {(PW+1){1'b0}};
      rd_ptr_q    <= {(PW+1){1'b0}};
      count_q     <= {(PW+1){1'b0}};
      full_q      <= 1'b0;
      ext_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      ext_addr_q  <= {AW{1'b0}};
      ext_data_q  <= {NUBITS{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      ext_valid_q <= ext_valid_d;
      ovf_q       <= ovf_d;
      ext_addr_q  <= ext_addr_d;
      ext_data_q  <= ext_data_d;
    end
  end

  assign ext_valid = ext_valid_q;
  assign ext_addr  = ext_addr_q;
  assign ext_data  = ext_data_q;
  assign full      = full_q;
  assign count     = count_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_io_out_fifo.sv
// Directed self-checking bench for io_out_fifo (NUBITS=32, NUIOOU=8, FDEPTH=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_io_out_fifo;

  logic        clk;
  logic        rst;
  logic        out_en;
  logic [2:0]  addr_out;
  logic [31:0] data_out;
  logic        ext_valid;
  logic [2:0]  ext_addr;
  logic [31:0] ext_data;
  logic        ext_ready;
  logic        full;
  logic [3:0]  count;
  logic        ovf;
  logic        ovf_clr;

  int checks = 0;
  int errors = 0;

  io_out_fifo #(
    .NUBITS (32),
    .NUIOOU (8),
    .FDEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .out_en    (out_en),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .ext_valid (ext_valid),
    .ext_addr  (ext_addr),
    .ext_data  (ext_data),
    .ext_ready (ext_ready),
    .full      (full),
    .count     (count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Push one entry per cycle: data = base+1 .. base+n, addr = low bits of data.
  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 1; i <= n; i++) begin
      out_en   = 1'b1;
      data_out = base + 32'(i);
      addr_out = 3'(base + 32'(i));
      cyc();
    end
    out_en = 1'b0;
  endtask

  logic [34:0] mq[$];
  logic [34:0] ent;
  logic        m_pop;
  logic        m_push;

  initial begin
    rst = 1'b1; out_en = 1'b0; addr_out = 3'd0; data_out = 32'd0;
    ext_ready = 1'b0; ovf_clr = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // 1. reset / idle
    cyc(); cyc(); cyc();
    chk("t1_valid", 64'(ext_valid), 64'd0);
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_full", 64'(full), 64'd0);
    chk("t1_ovf", 64'(ovf), 64'd0);
    chk("t1_data", 64'(ext_data), 64'd0);
    chk("t1_addr", 64'(ext_addr), 64'd0);

    // 2. single write, hold, single pop
    out_en = 1'b1; addr_out = 3'd3; data_out = 32'h0000_1234;
    cyc();
    out_en = 1'b0;
    chk("t2_valid", 64'(ext_valid), 64'd1);
    chk("t2_addr", 64'(ext_addr), 64'd3);
    chk("t2_data", 64'(ext_data), 64'h1234);
    chk("t2_count", 64'(count), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_hold_valid", 64'(ext_valid), 64'd1);
      chk("t2_hold_data", 64'(ext_data), 64'h1234);
      chk("t2_hold_addr", 64'(ext_addr), 64'd3);
    end
    ext_ready = 1'b1;
    cyc();
    ext_ready = 1'b0;
    chk("t2_pop_valid", 64'(ext_valid), 64'd0);
    chk("t2_pop_count", 64'(count), 64'd0);
    chk("t2_pop_data", 64'(ext_data), 64'd0);

    // 3. fill to full, overflow, drain in order
    fill(8, 32'd0);
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_count", 64'(count), 64'd8);
    chk("t3_ovf0", 64'(ovf), 64'd0);
    out_en = 1'b1; data_out = 32'd9; addr_out = 3'd1;
    cyc();
    out_en = 1'b0;
    chk("t3_ovf", 64'(ovf), 64'd1);
    chk("t3_count_ovf", 64'(count), 64'd8);
    ext_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t3_drain_valid", 64'(ext_valid), 64'd1);
      chk("t3_drain_data", 64'(ext_data), 64'(i));
      chk("t3_drain_addr", 64'(ext_addr), 64'(i % 8));
      cyc();
    end
    ext_ready = 1'b0;
    chk("t3_empty_valid", 64'(ext_valid), 64'd0);
    chk("t3_empty_count", 64'(count), 64'd0);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 64'(ovf), 64'd0);

    // 4. full with simultaneous push and pop
    fill(8, 32'h10);
    chk("t4_full", 64'(full), 64'd1);
    out_en = 1'b1; data_out = 32'hAA; addr_out = 3'd2; ext_ready = 1'b1;
    cyc();
    out_en = 1'b0; ext_ready = 1'b0;
    chk("t4_ovf", 64'(ovf), 64'd0);
    chk("t4_count", 64'(count), 64'd8);
    chk("t4_full2", 64'(full), 64'd1);
    chk("t4_head", 64'(ext_data), 64'h12);
    ext_ready = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      chk("t4_drain_data", 64'(ext_data), 64'(32'h10 + 32'(i)));
      cyc();
    end
    chk("t4_last_data", 64'(ext_data), 64'hAA);
    chk("t4_last_addr", 64'(ext_addr), 64'd2);
    cyc();
    ext_ready = 1'b0;
    chk("t4_empty", 64'(ext_valid), 64'd0);

    // 5. 20 writes on even cycles, ext_ready on odd cycles, queue model
    mq.delete();
    for (int c = 0; c < 40; c++) begin
      out_en    = (c % 2 == 0);
      data_out  = 32'h500 + 32'(c * 7);
      addr_out  = 3'(c / 2);
      ext_ready = (c % 2 == 1);
      chk("t5_valid", 64'(ext_valid), 64'(mq.size() != 0));
      chk("t5_count", 64'(count), 64'(mq.size()));
      if (mq.size() != 0) begin
        chk("t5_data", {29'd0, ext_addr, ext_data}, 64'(mq[0]));
      end
      m_pop  = (mq.size() != 0) && ext_ready;
      m_push = out_en && ((mq.size() < 8) || m_pop);
      if (m_pop) ent = mq.pop_front();
      if (m_push) mq.push_back({addr_out, data_out});
      cyc();
    end
    out_en = 1'b0; ext_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("t5_drain_valid", 64'(ext_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("t5_drain_data", {29'd0, ext_addr, ext_data}, 64'(mq[0]));
        ent = mq.pop_front();
      end
      cyc();
    end
    ext_ready = 1'b0;
    chk("t5_final_count", 64'(count), 64'd0);
    chk("t5_ovf", 64'(ovf), 64'd0);

    // 6. ovf set beats ovf_clr on the same edge
    fill(8, 32'h700);
    out_en = 1'b1; data_out = 32'h7FF;
    cyc();
    out_en = 1'b0;
    chk("t6_ovf_set", 64'(ovf), 64'd1);
    out_en = 1'b1; ovf_clr = 1'b1;
    cyc();
    out_en = 1'b0;
    chk("t6_ovf_set_wins", 64'(ovf), 64'd1);
    cyc();
    ovf_clr = 1'b0;
    chk("t6_ovf_cleared", 64'(ovf), 64'd0);
    chk("t6_count", 64'(count), 64'd8);

    // 7. reset with 5 entries queued
    ext_ready = 1'b1;
    cyc(); cyc(); cyc();
    ext_ready = 1'b0;
    chk("t7_count5", 64'(count), 64'd5);
    chk("t7_head", 64'(ext_data), 64'h704);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_async_valid", 64'(ext_valid), 64'd0);
    chk("t7_async_count", 64'(count), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("t7_post_count", 64'(count), 64'd0);
    chk("t7_post_valid", 64'(ext_valid), 64'd0);
    out_en = 1'b1; addr_out = 3'd5; data_out = 32'hCAFE;
    cyc();
    out_en = 1'b0;
    chk("t7_new_valid", 64'(ext_valid), 64'd1);
    chk("t7_new_addr", 64'(ext_addr), 64'd5);
    chk("t7_new_data", 64'(ext_data), 64'hCAFE);
    chk("t7_new_count", 64'(count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
